array_divider: RTL and testbench

//  Unsigned restoring array divider, the inverse datapath of the team's array multiplier.

---
 rtl/divider_pkg.sv | 32 +++
 rtl/divider_row.sv | 23 ++
 rtl/pipeline_stage.sv | 23 ++
 rtl/array_divider.sv | 151 +++++++++++++++
 tb/tb_array_divider.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/divider_pkg.sv
// Shared helpers for the array divider: stage-enable mask and stage payload widths.
package divider_pkg;

  localparam int unsigned MaxStages = 64;

  // Low n bits of a width-bit mask are set; the rest are clear.
  function automatic logic [MaxStages-1:0] stage_mask(input int unsigned width,
                                                      input int unsigned n);
    logic [MaxStages-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < MaxStages; i++) begin
      if (i < width && i < n) m[i] = 1'b1;
    end
    return m;
  endfunction

  // {A, B, valid}
  function automatic int unsigned in_payload_width(input int unsigned dw);
    return 2 * dw + 1;
  endfunction

  // {Q, R, div_by_zero, valid}
  function automatic int unsigned out_payload_width(input int unsigned dw);
    return 2 * dw + 2;
  endfunction

  // {rem, quot, divisor, dbz, valid} between rows
  function automatic int unsigned bundle_width(input int unsigned dw);
    return 3 * dw + 2;
  endfunction

endpackage

// File: rtl/divider_row.sv
// One restoring-division row: shift in a dividend bit, subtract the divisor, keep the
// difference only when it did not borrow.
module divider_row #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic             a_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic             q_bit
);

  logic [WIDTH:0] rem;
  logic [WIDTH:0] diff;

  assign rem  = {rem_in, a_bit};
  assign diff = rem - {1'b0, divisor};
  assign q_bit = ~diff[WIDTH];
  // Either choice is below the divisor (or equals the shifted dividend when it is 0),
  // so the top bit is always clear and can be dropped.
  assign rem_out = q_bit ? diff[WIDTH-1:0] : rem[WIDTH-1:0];

endmodule

// File: rtl/pipeline_stage.sv
// Optional register stage: a reset-to-zero flop bank when enabled, a plain wire otherwise.
module pipeline_stage #(
  parameter int unsigned WIDTH  = 1,
  parameter bit          ENABLE = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out
);

  if (ENABLE) begin : g_reg
    always_ff @(posedge clk or posedge rst) begin
      if (rst) data_out <= '0;
      else     data_out <= data_in;
    end
  end else begin : g_wire
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;
    assign data_out = data_in;
  end

endmodule

// File: rtl/array_divider.sv
// Unsigned restoring array divider: DATAWIDTH conditional-subtract rows with a register
// stage optionally inserted before, between and after the rows.
module array_divider
  import divider_pkg::*;
#(
  parameter int unsigned DATAWIDTH           = 4,
  parameter int unsigned NUM_PIPELINE_STAGES = 1,
  parameter int unsigned INSTANCE_ID         = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_valid,
  input  logic [DATAWIDTH-1:0] A,
  input  logic [DATAWIDTH-1:0] B,
  output logic                 o_valid,
  output logic [DATAWIDTH-1:0] Q,
  output logic [DATAWIDTH-1:0] R,
  output logic                 o_div_by_zero
);

  localparam int unsigned StageMaskWidth = DATAWIDTH + 2;
  localparam logic [MaxStages-1:0] StageMask = stage_mask(StageMaskWidth, NUM_PIPELINE_STAGES);
  localparam int unsigned InW  = in_payload_width(DATAWIDTH);
  localparam int unsigned OutW = out_payload_width(DATAWIDTH);
  localparam int unsigned unused_instance_id = INSTANCE_ID;

  if (DATAWIDTH < 2 || NUM_PIPELINE_STAGES < 1 ||
      NUM_PIPELINE_STAGES > StageMaskWidth) begin : g_bad_cfg
    $error("array_divider: unsupported DATAWIDTH/NUM_PIPELINE_STAGES");
  end

  // quot starts as the dividend and shifts left one bit per row, consuming dividend bits
  // at the top and collecting quotient bits at the bottom.
  typedef struct packed {
    logic [DATAWIDTH-1:0] rem;
    logic [DATAWIDTH-1:0] quot;
    logic [DATAWIDTH-1:0] divisor;
    logic                 dbz;
    logic                 valid;
  } stage_t;

  // The divisor is dead after the last row, so the final bundle omits it.
  typedef struct packed {
    logic [DATAWIDTH-1:0] rem;
    logic [DATAWIDTH-1:0] quot;
    logic                 dbz;
    logic                 valid;
  } tail_t;

  logic [InW-1:0]       in_d;
  logic [InW-1:0]       in_q;
  logic [DATAWIDTH-1:0] s0_a;
  logic [DATAWIDTH-1:0] s0_b;
  logic                 s0_valid;
  stage_t               head;
  stage_t               row_in [DATAWIDTH];
  tail_t                tail;
  logic [DATAWIDTH-1:0] q_gated;
  logic [OutW-1:0]      out_d;
  logic [OutW-1:0]      out_q;

  assign in_d = {A, B, i_valid};

  pipeline_stage #(
    .WIDTH (InW),
    .ENABLE(StageMask[0])
  ) u_stage_in (
    .clk     (clk),
    .rst     (rst),
    .data_in (in_d),
    .data_out(in_q)
  );

  assign {s0_a, s0_b, s0_valid} = in_q;

  // Idle slots feed zeros so the array output is clean whenever valid is low.
  always_comb begin
    head.rem     = '0;
    head.quot    = s0_valid ? s0_a : '0;
    head.divisor = s0_valid ? s0_b : '0;
    head.dbz     = s0_valid & (s0_b == '0);
    head.valid   = s0_valid;
  end

  assign row_in[0] = head;

  for (genvar r = 0; r < DATAWIDTH; r++) begin : g_row
    logic [DATAWIDTH-1:0] rem_next;
    logic [DATAWIDTH-1:0] quot_next;
    logic                 q_bit;

    divider_row #(
      .WIDTH(DATAWIDTH)
    ) u_row (
      .rem_in (row_in[r].rem),
      .a_bit  (row_in[r].quot[DATAWIDTH-1]),
      .divisor(row_in[r].divisor),
      .rem_out(rem_next),
      .q_bit  (q_bit)
    );

    assign quot_next = {row_in[r].quot[DATAWIDTH-2:0], q_bit};

    if (r < DATAWIDTH - 1) begin : g_mid
      stage_t nxt;
      assign nxt = '{rem: rem_next, quot: quot_next, divisor: row_in[r].divisor,
                     dbz: row_in[r].dbz, valid: row_in[r].valid};

      pipeline_stage #(
        .WIDTH ($bits(stage_t)),
        .ENABLE(StageMask[r+1])
      ) u_stage (
        .clk     (clk),
        .rst     (rst),
        .data_in (nxt),
        .data_out(row_in[r+1])
      );
    end else begin : g_last
      tail_t nxt;
      assign nxt = '{rem: rem_next, quot: quot_next, dbz: row_in[r].dbz,
                     valid: row_in[r].valid};

      pipeline_stage #(
        .WIDTH ($bits(tail_t)),
        .ENABLE(StageMask[r+1])
      ) u_stage (
        .clk     (clk),
        .rst     (rst),
        .data_in (nxt),
        .data_out(tail)
      );
    end
  end

  // A zero dividend/divisor pair yields an all-ones quotient, so idle slots are masked here.
  assign q_gated = tail.valid ? tail.quot : '0;
  assign out_d   = {q_gated, tail.rem, tail.dbz, tail.valid};

  pipeline_stage #(
    .WIDTH (OutW),
    .ENABLE(StageMask[DATAWIDTH+1])
  ) u_stage_out (
    .clk     (clk),
    .rst     (rst),
    .data_in (out_d),
    .data_out(out_q)
  );

  assign {Q, R, o_div_by_zero, o_valid} = out_q;

endmodule

// File: tb/tb_array_divider.sv
// Scoreboard bench: three dividers (1, 3 and 6 stages) share one stimulus stream; each has
// its own expected-result queue and monitor.
module tb_array_divider;

  localparam int unsigned DW   = 4;
  localparam int          NDUT = 3;

  typedef struct {
    int unsigned   cyc;
    logic [DW-1:0] q;
    logic [DW-1:0] r;
    logic          dbz;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          i_valid = 1'b0;
  logic [DW-1:0] a = '0;
  logic [DW-1:0] b = '0;

  logic          o_valid [NDUT];
  logic [DW-1:0] q       [NDUT];
  logic [DW-1:0] r       [NDUT];
  logic          dbz     [NDUT];

  exp_t        exp_q [NDUT][$];
  int unsigned cyc    = 0;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int unsigned n_of(input int i);
    case (i)
      0:       return 1;
      1:       return 3;
      default: return 6;
    endcase
  endfunction

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    localparam int unsigned N = (g == 0) ? 1 : ((g == 1) ? 3 : 6);

    array_divider #(
      .DATAWIDTH          (DW),
      .NUM_PIPELINE_STAGES(N),
      .INSTANCE_ID        (g)
    ) u_dut (
      .clk          (clk),
      .rst          (rst),
      .i_valid      (i_valid),
      .A            (a),
      .B            (b),
      .o_valid      (o_valid[g]),
      .Q            (q[g]),
      .R            (r[g]),
      .o_div_by_zero(dbz[g])
    );

    always @(negedge clk) begin : mon
      exp_t e;
      checks++;
      if (o_valid[g]) begin
        if (exp_q[g].size() == 0) begin
          errors++;
          $display("FAIL spurious_valid n=%0d cyc=%0d: got Q=%0d R=%0d dbz=%0d, expected no valid",
                   N, cyc, q[g], r[g], dbz[g]);
        end else begin
          e = exp_q[g].pop_front();
          if (e.cyc != cyc || q[g] !== e.q || r[g] !== e.r || dbz[g] !== e.dbz) begin
            errors++;
            $display("FAIL result n=%0d: got cyc=%0d Q=%0d R=%0d dbz=%0d, expected cyc=%0d Q=%0d R=%0d dbz=%0d",
                     N, cyc, q[g], r[g], dbz[g], e.cyc, e.q, e.r, e.dbz);
          end
        end
      end else begin
        if (q[g] !== '0 || r[g] !== '0 || dbz[g] !== 1'b0) begin
          errors++;
          $display("FAIL idle_zero n=%0d cyc=%0d: got Q=%0d R=%0d dbz=%0d, expected all 0",
                   N, cyc, q[g], r[g], dbz[g]);
        end
        if (exp_q[g].size() != 0 && exp_q[g][0].cyc <= cyc) begin
          e = exp_q[g].pop_front();
          errors++;
          $display("FAIL missing_valid n=%0d cyc=%0d: got o_valid=0, expected Q=%0d R=%0d at cyc=%0d",
                   N, cyc, e.q, e.r, e.cyc);
        end
      end
    end
  end

  // Drive one slot (called just after a rising edge) and queue the result if it is valid.
  task automatic issue(input logic v, input logic [DW-1:0] av, input logic [DW-1:0] bv,
                       input logic [DW-1:0] eq, input logic [DW-1:0] er, input logic ed);
    i_valid = v;
    a = av;
    b = bv;
    if (v) begin
      for (int i = 0; i < NDUT; i++) begin
        exp_q[i].push_back('{cyc: cyc + n_of(i), q: eq, r: er, dbz: ed});
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic issue_model(input logic v, input logic [DW-1:0] av, input logic [DW-1:0] bv);
    if (bv == '0) issue(v, av, bv, '1, av, 1'b1);
    else          issue(v, av, bv, av / bv, av % bv, 1'b0);
  endtask

  task automatic idle(input int n);
    i_valid = 1'b0;
    a = '0;
    b = '0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_cleared(input string name);
    for (int i = 0; i < NDUT; i++) begin
      checks++;
      if (o_valid[i] !== 1'b0 || q[i] !== '0 || r[i] !== '0 || dbz[i] !== 1'b0) begin
        errors++;
        $display("FAIL %s n=%0d: got o_valid=%0d Q=%0d R=%0d dbz=%0d, expected all 0",
                 name, n_of(i), o_valid[i], q[i], r[i], dbz[i]);
      end
    end
  endtask

  initial begin
    logic [4:0] pattern;
    pattern = 5'b10110;

    #1 rst = 1'b1;
    #1 check_cleared("reset_state");
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;

    // Single operation
    issue(1'b1, 4'd13, 4'd3, 4'd4, 4'd1, 1'b0);
    idle(8);

    // Back-to-back
    issue(1'b1, 4'd15, 4'd1, 4'd15, 4'd0, 1'b0);
    issue(1'b1, 4'd2,  4'd9, 4'd0,  4'd2, 1'b0);
    issue(1'b1, 4'd8,  4'd8, 4'd1,  4'd0, 1'b0);
    idle(8);

    // Divide by zero, then the same operands in an idle slot
    issue(1'b1, 4'd7, 4'd0, 4'd15, 4'd7, 1'b1);
    issue(1'b0, 4'd7, 4'd0, 4'd0,  4'd0, 1'b0);
    idle(8);

    // Reset with work in flight: everything queued is discarded
    issue(1'b1, 4'd10, 4'd3, 4'd3, 4'd1, 1'b0);
    issue(1'b1, 4'd10, 4'd3, 4'd3, 4'd1, 1'b0);
    issue(1'b1, 4'd10, 4'd3, 4'd3, 4'd1, 1'b0);
    i_valid = 1'b0;
    #2 rst = 1'b1;
    for (int i = 0; i < NDUT; i++) exp_q[i].delete();
    #1 check_cleared("reset_midflight");
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    // First slot after release must be accepted
    issue(1'b1, 4'd9, 4'd4, 4'd2, 4'd1, 1'b0);
    idle(8);

    // Valid pattern 1,0,1,1,0 with random operands
    for (int k = 4; k >= 0; k--) begin
      issue_model(pattern[k], 4'($urandom_range(15)), 4'($urandom_range(15)));
    end
    idle(8);

    // Exhaustive stream
    for (int ai = 0; ai < 16; ai++) begin
      for (int bi = 0; bi < 16; bi++) begin
        issue_model(1'b1, 4'(ai), 4'(bi));
      end
    end
    idle(10);

    for (int i = 0; i < NDUT; i++) begin
      checks++;
      if (exp_q[i].size() != 0) begin
        errors++;
        $display("FAIL dropped n=%0d: got %0d results outstanding, expected 0",
                 n_of(i), exp_q[i].size());
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
